adc_stream_fifo_mc: RTL
=======================

# adc_stream_fifo_mc

Multi-channel, parametrised successor of the single-channel ADC stream FIFO. It buffers channel-tagged ADC samples from the ADC capture front-end for firmware to drain over Wishbone. New capabilities:
- configurable sample width, depth and channel count;
- per-channel enable mask;
- selectable overflow policy (drop-newest or drop-oldest);
- saturating drop counter, watermark flag and high-water mark;
- synchronous flush.

## Interface
Parameters:
- DATA_W, 24, sample width in bits (1..32)
- N_CH, 4, number of ADC channels (>= 1); CH_W = max(1, $clog2(N_CH))
- DEPTH_WORDS, 64, FIFO depth in entries (>= 2; power of two not required); COUNT_W = $clog2(DEPTH_WORDS+1)

Ports:
- clk  in  1  the single clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- push_valid  in  1  sample offered by the front-end
- push_ch  in  CH_W  channel index of the offered sample
- push_data  in  DATA_W  sample value
- push_ready  out  1  FIFO accepts the offered sample this cycle
- pop_valid  out  1  head entry available
- pop_ch  out  CH_W  channel tag of the head entry
- pop_data  out  DATA_W  sample value of the head entry
- pop_ready  in  1  consumer takes the head entry this cycle
- ch_enable  in  N_CH  per-channel enable mask
- drop_oldest  in  1  overflow policy: 0 = drop newest, 1 = overwrite oldest
- watermark  in  COUNT_W  level threshold for the watermark flag
- flush  in  1  synchronous discard of all contents
- overrun_clear  in  1  clears overrun_sticky and drop_count (W1C pulse from the register level)
- max_clear  in  1  clears level_max
- level_words  out  COUNT_W  current occupancy, 0..DEPTH_WORDS
- level_max  out  COUNT_W  high-water mark of level_words
- wm_flag  out  1  level_words >= watermark and watermark != 0
- overrun_sticky  out  1  set when any enabled sample is dropped
- drop_count  out  16  count of dropped enabled samples; saturates at 0xFFFF

## Operation
- Storage is a DEPTH_WORDS x (CH_W+DATA_W) array holding {ch, data}. There is no reset on the array.
- rd_ptr and wr_ptr each wrap explicitly from DEPTH_WORDS-1 to 0.
- Gating: an offered sample is *eligible* when push_ch < N_CH and ch_enable[push_ch] = 1. A non-eligible sample is acknowledged (push_ready = 1) and discarded. It does not change the level and is not counted as a drop.
- push_ready is 1 unless the FIFO is full, drop_oldest = 0 and the sample is eligible.
- Write when not full: entry written at wr_ptr; wr_ptr advances; count +1.
- Write when full, pop_ready = 0:
  - drop_oldest = 0: push_ready = 0; no write; one drop is counted.
  - drop_oldest = 1: the entry at wr_ptr (the oldest) is overwritten; both pointers advance; count is unchanged; one drop is counted.
- Write and pop in the same cycle with the FIFO not empty: both pointers advance and count is unchanged. This includes the full case, which is not a drop.
- Pop on empty: ignored.
- Pop outputs: pop_valid = (count != 0). pop_ch and pop_data are combinational from the head entry and are forced to 0 when empty.
- Flush: pointers and count go to 0 next cycle. Flush has priority over push and pop in the same cycle; both are discarded and no drop is counted. Flush does not clear overrun_sticky, drop_count or level_max.
- Drop accounting: on a drop, overrun_sticky is set and drop_count increments, saturating at 0xFFFF.
  - overrun_clear alone sets overrun_sticky = 0 and drop_count = 0.
  - overrun_clear together with a drop gives overrun_sticky = 1 and drop_count = 1 (the drop wins).
- level_max updates to max(level_max, next count) every cycle. max_clear loads it with the next count, not 0.
- wm_flag is combinational from count and watermark.

## Timing
- Reset state: count = 0, level_words = 0, level_max = 0, pointers = 0, pop_valid = 0, pop_ch = 0, pop_data = 0, push_ready = 1, wm_flag = 0, overrun_sticky = 0, drop_count = 0.
- Reset assertion is asynchronous. Reset release is used synchronously inside the block; the enclosing design synchronises rst_n deassertion.
- Reset asserted mid-stream discards all contents immediately.
- Latency: a sample accepted in cycle N is visible on pop_* and counted in level_words in cycle N+1 (first-word fall-through).
- Pop handshake: pop_valid && pop_ready in cycle N; the next head is presented in cycle N+1.
- push_ready depends combinationally on count, drop_oldest, push_ch and ch_enable. It has no path from pop_ready, so no combinational loop through the FIFO.
- Status (drop_count, overrun_sticky, level_max) updates one cycle after the causing event.

## Test plan
- Reset, then 3 pushes on ch 2 of 0x000123, 0x000456, 0x000789 with N_CH = 4 and all channels enabled → pop order and values match, pop_ch = 2 each, level_words 3 → 0, drop_count = 0.
- ch_enable = 4'b0101, one push on each of ch 0..3 → only the ch0 and ch2 samples are stored; level_words = 2; push_ready = 1 throughout; drop_count = 0.
- DEPTH_WORDS = 5, drop_oldest = 0: 7 pushes of values 1..7 with no pops → push_ready = 0 on pushes 6 and 7; drop_count = 2; overrun_sticky = 1; pops return 1..5.
- DEPTH_WORDS = 5, drop_oldest = 1: 7 pushes of values 1..7 → push_ready = 1 throughout; drop_count = 2; pops return 3..7, exercising pointer wrap.
- Full FIFO, simultaneous push and pop for 10 cycles → no drops; level_words stays at 5; data order is preserved.
- Drop and overrun_clear in the same cycle → overrun_sticky = 1, drop_count = 1.
- 0x10000 forced drops → drop_count = 0xFFFF.
- flush together with push → level_words = 0 next cycle; level_max is retained.
- watermark = 4: wm_flag rises on the cycle after the 4th accepted push.

Source files
------------

// File: rtl/adc_stream_fifo_mc.sv
// Multi-channel ADC sample FIFO: buffers channel-tagged samples for Wishbone draining,
// with per-channel gating, selectable overflow policy, drop accounting and level tracking.
module adc_stream_fifo_mc #(
   parameter int DATA_W = 24,
   parameter int N_CH = 4,
   parameter int DEPTH_WORDS = 64,
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int COUNT_W = $clog2(DEPTH_WORDS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_valid,
   input  logic [CH_W-1:0]    push_ch,
   input  logic [DATA_W-1:0]  push_data,
   output logic               push_ready,
   output logic               pop_valid,
   output logic [CH_W-1:0]    pop_ch,
   output logic [DATA_W-1:0]  pop_data,
   input  logic               pop_ready,
   input  logic [N_CH-1:0]    ch_enable,
   input  logic               drop_oldest,
   input  logic [COUNT_W-1:0] watermark,
   input  logic               flush,
   input  logic               overrun_clear,
   input  logic               max_clear,
   output logic [COUNT_W-1:0] level_words,
   output logic [COUNT_W-1:0] level_max,
   output logic               wm_flag,
   output logic               overrun_sticky,
   output logic [15:0]        drop_count
);

   localparam int PTR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int ENTRY_W = CH_W + DATA_W;
   localparam logic [COUNT_W-1:0] FULL_LEVEL = COUNT_W'(DEPTH_WORDS);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH_WORDS - 1);

   logic [ENTRY_W-1:0] mem [DEPTH_WORDS];
   logic [ENTRY_W-1:0] head;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [COUNT_W-1:0] count;
   logic [COUNT_W-1:0] count_next;
   logic               eligible;
   logic               full;
   logic               empty;
   logic               do_write;
   logic               do_pop;
   logic               rd_adv;
   logic               drop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Channel indices beyond N_CH never match, so they are treated as disabled.
   always_comb begin
      // NOTE: default assignment first so no path through this block leaves eligible
      // unassigned, which would otherwise infer a latch.
      eligible = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (push_ch == CH_W'(i)) eligible = ch_enable[i];
      end
   end

   assign full       = (count == FULL_LEVEL);
   assign empty      = (count == '0);
   assign push_ready = !(full && !drop_oldest && eligible);
   assign do_pop     = pop_ready && !empty && !flush;
   assign do_write   = push_valid && eligible && push_ready && !flush;
   assign drop       = push_valid && eligible && full && !pop_ready && !flush;
   // A write into a full FIFO always retires the oldest entry, by pop or by overwrite.
   assign rd_adv     = do_pop || (do_write && full);

   always_comb begin
      count_next = count;
      if (flush)                             count_next = '0;
      else if (do_write && !full && !do_pop) count_next = count + COUNT_W'(1);
      else if (do_pop && !do_write)          count_next = count - COUNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         level_max      <= '0;
         overrun_sticky <= 1'b0;
         drop_count     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples pre-edge values.
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (do_write) wr_ptr <= next_ptr(wr_ptr);
            if (rd_adv)   rd_ptr <= next_ptr(rd_ptr);
         end
         count <= count_next;
         if (max_clear || (count_next > level_max)) level_max <= count_next;
         if (drop) begin
            overrun_sticky <= 1'b1;
            if (overrun_clear)               drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end else if (overrun_clear) begin
            overrun_sticky <= 1'b0;
            drop_count     <= '0;
         end
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by count alone, and
   // leaving it unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr] <= {push_ch, push_data};
   end

   assign head        = mem[rd_ptr];
   assign pop_valid   = !empty;
   assign pop_ch      = empty ? '0 : head[ENTRY_W-1:DATA_W];
   assign pop_data    = empty ? '0 : head[DATA_W-1:0];
   assign level_words = count;
   assign wm_flag     = (watermark != '0) && (count >= watermark);

endmodule
